// File: rtl/cci_mpf_shim_canonicalize_buf.sv
// Buffered canonicalization shim on the MPF request path toward the FIU.
// Each channel queues AFU headers in a FIFO. At issue it rewrites
// byte-mode addresses to line addresses, then issues the header to the
// FIU under FIU almost-full control.
// Optional feature macro: CCI_MPF_CANON_SPLIT_EN. When defined,
// multi-line requests are split into single-line beats.
module cci_mpf_shim_canonicalize_buf #(
    parameter int unsigned NUM_CHAN      = 2,
    parameter int unsigned ADDR_W        = 42,
    parameter int unsigned MDATA_W       = 16,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned ALMFULL_SLACK = 4,
    localparam int unsigned HDR_W        = MDATA_W + 3 + ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CHAN-1:0]       afu_valid,
    input  logic [NUM_CHAN*HDR_W-1:0] afu_hdr,
    output logic [NUM_CHAN-1:0]       afu_almfull,
    output logic [NUM_CHAN-1:0]       fiu_valid,
    output logic [NUM_CHAN*HDR_W-1:0] fiu_hdr,
    input  logic [NUM_CHAN-1:0]       fiu_almfull,
    output logic [NUM_CHAN-1:0]       overflow
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned AF_LVL = DEPTH - ALMFULL_SLACK;

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        logic [HDR_W-1:0]   mem_q [DEPTH];
        logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
        logic [CNT_W-1:0]   count_q, count_d;
        logic               valid_q, ovf_q;
        logic [HDR_W-1:0]   hdr_q;
        logic [HDR_W-1:0]   head, out_hdr;
        logic [ADDR_W-1:0]  canon_addr;
        logic [MDATA_W-1:0] head_mdata;
        logic [1:0]         head_cl_len;
        logic               issue, deq, enq;

        assign head        = mem_q[rd_ptr_q];
        assign head_mdata  = head[HDR_W-1 -: MDATA_W];
        assign head_cl_len = head[ADDR_W+1:ADDR_W];
        assign canon_addr  = head[ADDR_W+2] ? (head[ADDR_W-1:0] >> 6) : head[ADDR_W-1:0];
        assign issue       = (count_q != '0) && !fiu_almfull[i];
        assign enq         = afu_valid[i] && ((count_q != CNT_W'(DEPTH)) || deq);

`ifdef CCI_MPF_CANON_SPLIT_EN
        typedef enum logic {ST_IDLE, ST_SPLIT} state_t;
        state_t     state_q;
        logic [1:0] beat_q;
        logic       last_beat;

        assign last_beat = (state_q == ST_IDLE) ? (head_cl_len == 2'd0) : (beat_q == head_cl_len);
        assign deq       = issue && last_beat;
        assign out_hdr   = {head_mdata, 1'b0, 2'b00, canon_addr + ADDR_W'(beat_q)};

        // Split FSM: walks the beats of the head entry; FIU stalls hold the beat
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= ST_IDLE;
                beat_q  <= 2'd0;
            end else if (issue) begin
                if (last_beat) begin
                    state_q <= ST_IDLE;
                    beat_q  <= 2'd0;
                end else begin
                    state_q <= ST_SPLIT;
                    beat_q  <= beat_q + 2'd1;
                end
            end
        end
`else
        assign deq     = issue;
        assign out_hdr = {head_mdata, 1'b0, head_cl_len, canon_addr};
`endif

        // Occupancy next state: a simultaneous enq and deq leaves the count unchanged
        always_comb begin
            count_d = count_q;
            if (enq && !deq) begin
                count_d = count_q + CNT_W'(1);
            end else if (deq && !enq) begin
                count_d = count_q - CNT_W'(1);
            end
        end

        // FIFO storage; no reset is needed because the count qualifies every read
        always_ff @(posedge clk) begin
            if (enq) begin
                mem_q[wr_ptr_q] <= afu_hdr[i*HDR_W +: HDR_W];
            end
        end

        // Pointers and count
        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_d;
            end
        end

        // Registered FIU output and sticky overflow flag
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
                hdr_q   <= '0;
                ovf_q   <= 1'b0;
            end else begin
                valid_q <= issue;
                if (issue) hdr_q <= out_hdr;
                if (afu_valid[i] && !enq) ovf_q <= 1'b1;
            end
        end

        assign afu_almfull[i]               = (count_q >= CNT_W'(AF_LVL));
        assign fiu_valid[i]                 = valid_q;
        assign fiu_hdr[i*HDR_W +: HDR_W]    = hdr_q;
        assign overflow[i]                  = ovf_q;
    end

endmodule

// File: tb/tb_cci_mpf_shim_canonicalize_buf.sv
// Self-checking bench for cci_mpf_shim_canonicalize_buf (default parameters).
// Follows CCI_MPF_CANON_SPLIT_EN in the same way as the design.
module tb_cci_mpf_shim_canonicalize_buf;

    localparam int unsigned NC      = 2;
    localparam int unsigned ADDR_W  = 42;
    localparam int unsigned MDATA_W = 16;
    localparam int unsigned HDR_W   = MDATA_W + 3 + ADDR_W;
    localparam int unsigned DEPTH   = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [NC-1:0]       afu_valid;
    logic [NC*HDR_W-1:0] afu_hdr;
    logic [NC-1:0]       afu_almfull;
    logic [NC-1:0]       fiu_valid;
    logic [NC*HDR_W-1:0] fiu_hdr;
    logic [NC-1:0]       fiu_almfull;
    logic [NC-1:0]       overflow;

    int checks = 0;
    int errors = 0;

    logic [HDR_W-1:0] exp_q [NC][$];

    cci_mpf_shim_canonicalize_buf dut (
        .clk        (clk),
        .reset      (reset),
        .afu_valid  (afu_valid),
        .afu_hdr    (afu_hdr),
        .afu_almfull(afu_almfull),
        .fiu_valid  (fiu_valid),
        .fiu_hdr    (fiu_hdr),
        .fiu_almfull(fiu_almfull),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [HDR_W-1:0] mk_hdr(input logic [MDATA_W-1:0] md, input logic bm,
                                                input logic [1:0] cl, input logic [ADDR_W-1:0] a);
        return {md, bm, cl, a};
    endfunction

    function automatic logic [HDR_W-1:0] rand_hdr();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return mk_hdr(MDATA_W'($urandom()), 1'($urandom_range(1)), 2'($urandom_range(3)), r[ADDR_W-1:0]);
    endfunction

    // Reference: what the FIU should see for one accepted AFU header
    task automatic push_exp(input int ch, input logic [HDR_W-1:0] h);
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] line;
        int n;
        a = h[ADDR_W-1:0];
        line = h[ADDR_W+2] ? ADDR_W'(a / 64) : a;
        n = int'(h[ADDR_W+1:ADDR_W]);
`ifdef CCI_MPF_CANON_SPLIT_EN
        for (int k = 0; k <= n; k++)
            exp_q[ch].push_back(mk_hdr(h[HDR_W-1 -: MDATA_W], 1'b0, 2'b00, line + ADDR_W'(k)));
`else
        exp_q[ch].push_back(mk_hdr(h[HDR_W-1 -: MDATA_W], 1'b0, 2'(n), line));
`endif
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; afu_valid = '0; fiu_almfull = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < NC; c++) exp_q[c].delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; afu_valid = '0; afu_hdr = '0; fiu_almfull = '0;
        repeat (2) @(negedge clk);
        checks++; if (fiu_valid !== '0)   begin errors++; $display("FAIL reset_fiu_valid got %b want 0", fiu_valid); end
        checks++; if (fiu_hdr !== '0)     begin errors++; $display("FAIL reset_fiu_hdr got %h want 0", fiu_hdr); end
        checks++; if (afu_almfull !== '0) begin errors++; $display("FAIL reset_almfull got %b want 0", afu_almfull); end
        checks++; if (overflow !== '0)    begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        reset = 1'b0;
    endtask

    task automatic test_latency();
        logic [HDR_W-1:0] want;
        apply_reset();
        afu_hdr[0 +: HDR_W] = mk_hdr(16'h1234, 1'b1, 2'd0, 42'h1C0);
        afu_valid = 2'b01;
        want = mk_hdr(16'h1234, 1'b0, 2'd0, 42'h7);
        @(negedge clk);
        afu_valid = '0;
        checks++; if (fiu_valid[0] !== 1'b0) begin errors++; $display("FAIL lat_t1 got %b want 0", fiu_valid[0]); end
        @(negedge clk);
        checks++; if (fiu_valid[0] !== 1'b1) begin errors++; $display("FAIL lat_t2_valid got %b want 1", fiu_valid[0]); end
        checks++; if (fiu_hdr[0 +: HDR_W] !== want) begin errors++; $display("FAIL lat_t2_hdr got %h want %h", fiu_hdr[0 +: HDR_W], want); end
        @(negedge clk);
        checks++; if (fiu_valid[0] !== 1'b0) begin errors++; $display("FAIL lat_pulse got %b want 0", fiu_valid[0]); end
        checks++; if (fiu_hdr[0 +: HDR_W] !== want) begin errors++; $display("FAIL lat_hold got %h want %h", fiu_hdr[0 +: HDR_W], want); end
    endtask

    task automatic test_almfull();
        apply_reset();
        fiu_almfull = 2'b10;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            afu_hdr[HDR_W +: HDR_W] = rand_hdr();
            afu_valid = 2'b10;
            @(negedge clk);
            afu_valid = '0;
            checks++;
            if (afu_almfull[1] !== (k >= 12)) begin
                errors++; $display("FAIL almfull_k%0d got %b want %b", k, afu_almfull[1], (k >= 12));
            end
            checks++;
            if (overflow[1] !== (k > int'(DEPTH))) begin
                errors++; $display("FAIL overflow_k%0d got %b want %b", k, overflow[1], (k > int'(DEPTH)));
            end
            checks++;
            if (fiu_valid !== '0) begin errors++; $display("FAIL almfull_issue_k%0d got %b want 00", k, fiu_valid); end
        end
        checks++; if (overflow[0] !== 1'b0) begin errors++; $display("FAIL overflow_ch0 got %b want 0", overflow[0]); end
    endtask

    task automatic test_stream();
        logic [NC-1:0]    prev_af;
        logic [HDR_W-1:0] h;
        apply_reset();
        prev_af = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < NC; c++) begin
                if (fiu_valid[c]) begin
                    checks++;
                    if (prev_af[c]) begin
                        errors++; $display("FAIL stream_gate ch%0d cyc%0d got valid after almfull", c, cyc);
                    end
                    checks++;
                    if (exp_q[c].size() == 0) begin
                        errors++; $display("FAIL stream_extra ch%0d got %h want none", c, fiu_hdr[c*HDR_W +: HDR_W]);
                    end else begin
                        h = exp_q[c].pop_front();
                        if (fiu_hdr[c*HDR_W +: HDR_W] !== h) begin
                            errors++; $display("FAIL stream_hdr ch%0d got %h want %h", c, fiu_hdr[c*HDR_W +: HDR_W], h);
                        end
                    end
                end
            end
            fiu_almfull = (cyc < 400) ? {NC{cyc[0]}} : '0;
            prev_af = fiu_almfull;
            for (int c = 0; c < NC; c++) begin
                afu_valid[c] = (cyc < 400) && !afu_almfull[c] && ($urandom_range(3) != 0);
                if (afu_valid[c]) begin
                    h = rand_hdr();
                    afu_hdr[c*HDR_W +: HDR_W] = h;
                    push_exp(c, h);
                end
            end
        end
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (exp_q[c].size() != 0) begin errors++; $display("FAIL stream_missing ch%0d got %0d left want 0", c, exp_q[c].size()); end
        end
        checks++; if (overflow !== '0) begin errors++; $display("FAIL stream_overflow got %b want 00", overflow); end
    endtask

    task automatic test_split();
        logic [HDR_W-1:0] h;
        int pulses;
        apply_reset();
        h = mk_hdr(16'hBEEF, 1'b0, 2'd3, 42'h100);
        push_exp(0, h);
        afu_hdr[0 +: HDR_W] = h;
        afu_valid = 2'b01;
        @(negedge clk);
        afu_valid = '0;
        pulses = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (fiu_valid[0]) begin
                pulses++;
                checks++;
                if (exp_q[0].size() == 0) begin
                    errors++; $display("FAIL split_extra got %h want none", fiu_hdr[0 +: HDR_W]);
                end else begin
                    h = exp_q[0].pop_front();
                    if (fiu_hdr[0 +: HDR_W] !== h) begin
                        errors++; $display("FAIL split_hdr beat%0d got %h want %h", pulses - 1, fiu_hdr[0 +: HDR_W], h);
                    end
                end
            end
        end
`ifdef CCI_MPF_CANON_SPLIT_EN
        checks++; if (pulses != 4) begin errors++; $display("FAIL split_pulses got %0d want 4", pulses); end
`else
        checks++; if (pulses != 1) begin errors++; $display("FAIL split_pulses got %0d want 1", pulses); end
`endif
    endtask

    task automatic test_reset_mid_split();
        int pulses;
        int stop_at;
`ifdef CCI_MPF_CANON_SPLIT_EN
        stop_at = 2;
`else
        stop_at = 1;
`endif
        apply_reset();
        fiu_almfull = 2'b10;
        for (int k = 0; k <= int'(DEPTH); k++) begin
            afu_hdr[HDR_W +: HDR_W] = rand_hdr();
            afu_valid = 2'b10;
            @(negedge clk);
        end
        afu_hdr[0 +: HDR_W] = mk_hdr(16'h0042, 1'b0, 2'd3, 42'h100);
        afu_valid = 2'b01;
        @(negedge clk);
        afu_valid = '0;
        checks++; if (overflow[1] !== 1'b1)    begin errors++; $display("FAIL mid_pre_ovf got %b want 1", overflow[1]); end
        checks++; if (afu_almfull[1] !== 1'b1) begin errors++; $display("FAIL mid_pre_af got %b want 1", afu_almfull[1]); end
        pulses = 0;
        for (int cyc = 0; cyc < 10 && pulses < stop_at; cyc++) begin
            @(negedge clk);
            if (fiu_valid[0]) pulses++;
        end
        checks++; if (pulses != stop_at) begin errors++; $display("FAIL mid_beats got %0d want %0d", pulses, stop_at); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (fiu_valid !== '0)   begin errors++; $display("FAIL mid_rst_valid got %b want 00", fiu_valid); end
        checks++; if (afu_almfull !== '0) begin errors++; $display("FAIL mid_rst_af got %b want 00", afu_almfull); end
        checks++; if (overflow !== '0)    begin errors++; $display("FAIL mid_rst_ovf got %b want 00", overflow); end
        reset = 1'b0;
        fiu_almfull = '0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            checks++;
            if (fiu_valid !== '0) begin errors++; $display("FAIL mid_post cyc%0d got %b want 00", cyc, fiu_valid); end
        end
    endtask

    initial begin
        reset = 1'b1; afu_valid = '0; afu_hdr = '0; fiu_almfull = '0;
        test_reset();
        test_latency();
        test_almfull();
        test_stream();
        test_split();
        test_reset_mid_split();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
